ls161_param_counter: RTL and testbench

//   Parametrised synchronous binary/modulo counter, next generation of the 4-bit LS161-style

---
 rtl/ls161_param_counter.sv | 78 +++++++
 tb/tb_ls161_param_counter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ls161_param_counter.sv
// Parametrised LS161-style counter: up/down, wrap or saturate at a programmable terminal, sticky overflow.
// Latency: Q, TC_PULSE and OVF update one CLK edge after their inputs; RCO is combinational (zero latency).
// Backpressure: none; counting is gated by ENP&ENT, and RCO drives the next stage's ENT when cascading.
module ls161_param_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             CLK,
    input  logic             CLR_n,
    input  logic             SCLR_n,
    input  logic             LOAD_n,
    input  logic [WIDTH-1:0] D,
    input  logic             ENP,
    input  logic             ENT,
    input  logic             UP,
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             TC_PULSE,
    output logic             OVF
);

    // Terminal count expressed in the counter's own width.
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);

    logic             term;
    logic             cnt_en;
    logic [WIDTH-1:0] q_nxt;
    logic             tc_nxt;
    logic             ovf_nxt;

    // Terminal detect follows Q and UP combinationally, so a direction change is seen at once.
    always_comb begin
        term = UP ? (Q == MAX_Q) : (Q == '0);
    end

    // Ripple carry is gated by ENT only, so ENP can pause a chain without breaking the carry.
    assign RCO    = ENT & term;
    assign cnt_en = ENP & ENT;

    // Next-state selection: synchronous clear beats load, load beats count, otherwise hold.
    always_comb begin
        q_nxt   = Q;
        tc_nxt  = 1'b0;
        ovf_nxt = OVF;
        if (!SCLR_n) begin
            q_nxt   = '0;
            ovf_nxt = 1'b0;
        end else if (!LOAD_n) begin
            // Loads above the terminal are clamped so Q stays within 0..MAX_VAL.
            q_nxt = (D > MAX_Q) ? MAX_Q : D;
        end else if (cnt_en) begin
            if (term) begin
                tc_nxt  = 1'b1;
                ovf_nxt = 1'b1;
                if (!SATURATE) begin
                    q_nxt = UP ? '0 : MAX_Q;
                end
            end else begin
                q_nxt = UP ? (Q + WIDTH'(1)) : (Q - WIDTH'(1));
            end
        end
    end

    // State register; CLR_n clears everything immediately and blocks all edges while low.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            Q        <= '0;
            TC_PULSE <= 1'b0;
            OVF      <= 1'b0;
        end else begin
            Q        <= q_nxt;
            TC_PULSE <= tc_nxt;
            OVF      <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_ls161_param_counter.sv
// Self-checking bench: decade wrap and decade saturate instances against an arithmetic model, plus a two-stage cascade.
// Latency: model advances at each rising edge; registered outputs compared on the falling edge, RCO before the edge.
// Backpressure: not applicable; all stimulus is driven by the bench.
module tb_ls161_param_counter;

    logic       CLK = 1'b0;
    logic       CLR_n;
    logic       SCLR_n, LOAD_n, ENP, ENT, UP;
    logic [3:0] D;

    logic [3:0] q_dec, q_sat;
    logic       rco_dec, rco_sat, tc_dec, tc_sat, ovf_dec, ovf_sat;

    logic       cas_sclr_n;
    logic [3:0] q_lo, q_hi;
    logic       rco_lo, rco_hi, tc_lo, tc_hi, ovf_lo, ovf_hi;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: index 0 = decade wrap, index 1 = decade saturate.
    int m_q   [2];
    bit m_tc  [2];
    bit m_ovf [2];
    localparam int MX = 9;

    always #5 CLK = ~CLK;

    ls161_param_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) u_dec (
        .CLK(CLK), .CLR_n(CLR_n), .SCLR_n(SCLR_n), .LOAD_n(LOAD_n), .D(D),
        .ENP(ENP), .ENT(ENT), .UP(UP),
        .Q(q_dec), .RCO(rco_dec), .TC_PULSE(tc_dec), .OVF(ovf_dec)
    );

    ls161_param_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) u_sat (
        .CLK(CLK), .CLR_n(CLR_n), .SCLR_n(SCLR_n), .LOAD_n(LOAD_n), .D(D),
        .ENP(ENP), .ENT(ENT), .UP(UP),
        .Q(q_sat), .RCO(rco_sat), .TC_PULSE(tc_sat), .OVF(ovf_sat)
    );

    ls161_param_counter #(.WIDTH(4)) u_lo (
        .CLK(CLK), .CLR_n(CLR_n), .SCLR_n(cas_sclr_n), .LOAD_n(1'b1), .D(4'd0),
        .ENP(1'b1), .ENT(1'b1), .UP(1'b1),
        .Q(q_lo), .RCO(rco_lo), .TC_PULSE(tc_lo), .OVF(ovf_lo)
    );

    ls161_param_counter #(.WIDTH(4)) u_hi (
        .CLK(CLK), .CLR_n(CLR_n), .SCLR_n(cas_sclr_n), .LOAD_n(1'b1), .D(4'd0),
        .ENP(1'b1), .ENT(rco_lo), .UP(1'b1),
        .Q(q_hi), .RCO(rco_hi), .TC_PULSE(tc_hi), .OVF(ovf_hi)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One edge of the behavioural model, using plain integer arithmetic on the count.
    function automatic void model_step(int i);
        int nxt;
        bit sat;
        sat = (i == 1);
        if (!SCLR_n) begin
            m_q[i] = 0; m_ovf[i] = 1'b0; m_tc[i] = 1'b0;
        end else if (!LOAD_n) begin
            m_q[i]  = (int'(D) > MX) ? MX : int'(D);
            m_tc[i] = 1'b0;
        end else if (ENP && ENT) begin
            nxt = UP ? m_q[i] + 1 : m_q[i] - 1;
            if (nxt > MX || nxt < 0) begin
                m_tc[i]  = 1'b1;
                m_ovf[i] = 1'b1;
                if (!sat) m_q[i] = UP ? 0 : MX;
            end else begin
                m_q[i]  = nxt;
                m_tc[i] = 1'b0;
            end
        end else begin
            m_tc[i] = 1'b0;
        end
    endfunction

    function automatic bit exp_rco(int i);
        return ENT && (UP ? (m_q[i] + 1 > MX) : (m_q[i] - 1 < 0));
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_q[i] = 0; m_tc[i] = 1'b0; m_ovf[i] = 1'b0;
        end
    endfunction

    task automatic check_state();
        chk("q_dec",   32'(q_dec),   32'(m_q[0]));
        chk("tc_dec",  32'(tc_dec),  32'(m_tc[0]));
        chk("ovf_dec", 32'(ovf_dec), 32'(m_ovf[0]));
        chk("q_sat",   32'(q_sat),   32'(m_q[1]));
        chk("tc_sat",  32'(tc_sat),  32'(m_tc[1]));
        chk("ovf_sat", 32'(ovf_sat), 32'(m_ovf[1]));
    endtask

    // Inputs are already driven (falling-edge time); check RCO, take one edge, check registers.
    task automatic step();
        #1;
        chk("rco_dec", 32'(rco_dec), 32'(exp_rco(0)));
        chk("rco_sat", 32'(rco_sat), 32'(exp_rco(1)));
        @(posedge CLK);
        model_step(0);
        model_step(1);
        @(negedge CLK);
        check_state();
    endtask

    task automatic drive(input bit sclr_n, input bit load_n, input int d, input bit enp, input bit ent, input bit up);
        SCLR_n = sclr_n; LOAD_n = load_n; D = 4'(d); ENP = enp; ENT = ent; UP = up;
    endtask

    initial begin
        CLR_n = 1'b0; cas_sclr_n = 1'b0;
        drive(1, 1, 0, 0, 0, 1);
        model_reset();
        repeat (2) @(negedge CLK);
        check_state();
        CLR_n = 1'b1;

        // Make OVF sticky-high first, then load 7 and assert async reset mid-cycle.
        drive(1, 0, 9, 0, 0, 1); step();
        drive(1, 1, 0, 1, 1, 1); step();
        chk("ovf_pre_reset", 32'(ovf_dec), 32'd1);
        drive(1, 0, 7, 0, 0, 1); step();
        chk("q_pre_reset", 32'(q_dec), 32'd7);
        #2 CLR_n = 1'b0;
        model_reset();
        #1;
        chk("async_q",   32'(q_dec),   32'd0);
        chk("async_ovf", 32'(ovf_dec), 32'd0);
        drive(1, 0, 5, 1, 1, 1);
        @(posedge CLK); @(negedge CLK);
        chk("hold_in_reset_q", 32'(q_dec), 32'd0);
        check_state();
        CLR_n = 1'b1;

        // Clear beats load; then load alone.
        drive(0, 0, 5, 1, 1, 1); step();
        chk("prio_clear", 32'(q_dec), 32'd0);
        drive(1, 0, 5, 1, 1, 1); step();
        chk("prio_load", 32'(q_dec), 32'd5);

        // Decade wrap upward.
        drive(1, 0, 8, 0, 0, 1); step();
        drive(1, 1, 0, 1, 1, 1); step();
        chk("dec_q9", 32'(q_dec), 32'd9);
        #1 chk("dec_rco9", 32'(rco_dec), 32'd1);
        step();
        chk("dec_wrap_q",  32'(q_dec),   32'd0);
        chk("dec_wrap_tc", 32'(tc_dec),  32'd1);
        chk("dec_wrap_ovf",32'(ovf_dec), 32'd1);
        step();
        chk("dec_tc_once", 32'(tc_dec),  32'd0);
        chk("dec_ovf_sticky", 32'(ovf_dec), 32'd1);

        // Downward saturate at zero.
        drive(1, 0, 1, 0, 0, 0); step();
        drive(1, 1, 0, 1, 1, 0); step();
        chk("sat_q0", 32'(q_sat), 32'd0);
        #1 chk("sat_rco0", 32'(rco_sat), 32'd1);
        step();
        chk("sat_hold_q", 32'(q_sat),   32'd0);
        chk("sat_tc",     32'(tc_sat),  32'd1);
        chk("sat_ovf",    32'(ovf_sat), 32'd1);
        chk("dec_down_wrap_q", 32'(q_dec), 32'd9);

        // Load clamp and enable gating of RCO.
        drive(1, 0, 13, 0, 0, 1); step();
        chk("clamp_q", 32'(q_dec), 32'd9);
        drive(1, 1, 0, 0, 1, 1); step();
        chk("enp_hold_q", 32'(q_dec), 32'd9);
        #1 chk("enp_rco", 32'(rco_dec), 32'd1);
        drive(1, 1, 0, 1, 0, 1);
        #1 chk("ent_rco", 32'(rco_dec), 32'd0);
        step();

        // Randomised traffic, including direction changes and occasional clears/loads.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 19) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 15),
                  $urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
                  ($urandom_range(0, 7) == 0) ? ~UP : UP);
            step();
        end

        // Two-stage cascade: 300 edges must read 300 mod 256.
        cas_sclr_n = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            @(posedge CLK); @(negedge CLK);
            if (n % 50 == 0 || n == 300)
                chk("cascade", 32'({q_hi, q_lo}), 32'(n % 256));
        end
        chk("cascade_final", 32'({q_hi, q_lo}), 32'd44);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
